// File: rtl/digit_ascii_encoder.sv
// Scans a 16x8 register file once per go, rewriting binary digits 0..9 as ASCII '0'..'9'.
// Optional DIGIT_ASCII_ERR_MARK_EN: non-digit, non-ASCII-digit entries are overwritten with '?'.
module digit_ascii_encoder #(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int ASCII_BASE = 48,
    parameter int MAX_DIGIT  = 9
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              go,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] R_Addr,
    output logic              R_en,
    input  logic [DATA_W-1:0] R_Data,
    output logic [ADDR_W-1:0] W_Addr,
    output logic              W_en,
    output logic [DATA_W-1:0] W_Data
`ifdef DIGIT_ASCII_ERR_MARK_EN
    ,
    output logic [ADDR_W:0]   err_count
`endif
);

    localparam logic [DATA_W-1:0] MAX_D   = DATA_W'(MAX_DIGIT);
    localparam logic [DATA_W-1:0] BASE    = DATA_W'(ASCII_BASE);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EVAL  = 3'd2,
        S_WRITE = 3'd3,
        S_NEXT  = 3'd4,
        S_DONE  = 3'd5
`ifdef DIGIT_ASCII_ERR_MARK_EN
        ,
        S_MARK  = 3'd6
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [DATA_W-1:0]   temp_q, temp_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                done_q, done_d;
`ifdef DIGIT_ASCII_ERR_MARK_EN
    logic [ADDR_W:0]     err_q, err_d;
    logic                is_ascii_digit;

    assign is_ascii_digit = (temp_q >= BASE) && (temp_q <= BASE + MAX_D);
    assign err_count      = err_q;
    assign W_Data         = (state_q == S_MARK) ? DATA_W'(63) : temp_q + BASE;
`else
    assign W_Data         = temp_q + BASE;
`endif

    assign R_Addr = i_q;
    assign W_Addr = i_q;
    assign done   = done_q;
    assign count  = count_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            temp_q  <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
`ifdef DIGIT_ASCII_ERR_MARK_EN
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            temp_q  <= temp_d;
            count_q <= count_d;
            done_q  <= done_d;
`ifdef DIGIT_ASCII_ERR_MARK_EN
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        temp_d  = temp_q;
        count_d = count_q;
        done_d  = done_q;
`ifdef DIGIT_ASCII_ERR_MARK_EN
        err_d   = err_q;
`endif
        R_en    = 1'b0;
        W_en    = 1'b0;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d = S_READ;
                    i_d     = '0;
                    count_d = '0;
                    done_d  = 1'b0;
`ifdef DIGIT_ASCII_ERR_MARK_EN
                    err_d   = '0;
`endif
                end
            end
            S_READ: begin
                busy    = 1'b1;
                R_en    = 1'b1;
                temp_d  = R_Data;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                busy = 1'b1;
                if (temp_q <= MAX_D)
                    state_d = S_WRITE;
`ifdef DIGIT_ASCII_ERR_MARK_EN
                else if (!is_ascii_digit)
                    state_d = S_MARK;
`endif
                else
                    state_d = S_NEXT;
            end
            S_WRITE: begin
                busy    = 1'b1;
                W_en    = 1'b1;
                count_d = count_q + CNT_ONE;
                state_d = S_NEXT;
            end
`ifdef DIGIT_ASCII_ERR_MARK_EN
            S_MARK: begin
                busy    = 1'b1;
                W_en    = 1'b1;
                err_d   = err_q + CNT_ONE;
                state_d = S_NEXT;
            end
`endif
            S_NEXT: begin
                busy = 1'b1;
                // Exit before incrementing so i never wraps past the last entry.
                if (i_q == LAST) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    i_d     = i_q + A_ONE;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                if (!go)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/digit_ascii_encoder.md
Name: digit_ascii_encoder

Overview:
- Walks a 16x8 register file once per `go`, reading each entry in address order.
- Entries holding a binary digit value 0..9 are rewritten in place as ASCII '0'..'9' (value + 48); other entries are left untouched.
- Counts the entries it converted.
- Inverse of the lab-exam digit scanner that turns ASCII digits into numeric values. Drives the existing RegFile16x8 port set as the read/write master.

Parameters:
- DEPTH, 16, number of register-file entries scanned (power of two).
- ADDR_W, 4, address width; log2(DEPTH).
- DATA_W, 8, register-file data width.
- ASCII_BASE, 48, offset added to a valid digit.
- MAX_DIGIT, 9, largest value treated as a valid digit.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  asynchronous reset, active-low (0 = reset).
- go  in  1  start request, level-sampled in IDLE.
- busy  out  1  high while a scan is in progress (READ..NEXT).
- done  out  1  scan complete, held until the next start.
- count  out  ADDR_W+1  number of entries converted in the last scan (0..DEPTH).
- R_Addr  out  ADDR_W  register-file read address.
- R_en  out  1  register-file read enable.
- R_Data  in  DATA_W  register-file read data; combinational, valid in the cycle R_en=1.
- W_Addr  out  ADDR_W  register-file write address.
- W_en  out  1  register-file write enable; write occurs at the rising edge while high.
- W_Data  out  DATA_W  register-file write data.

Behaviour:
- Reset (Rst=0, async): state=IDLE, i=0, temp=0, count=0, done=0. Combinational outputs R_en=0, W_en=0, busy=0.
- R_Addr and W_Addr always equal i. R_en, W_en and busy are Moore decodes of state. W_Data = temp + ASCII_BASE, truncated to DATA_W.
- States:
  - IDLE: go=1 -> READ; clear i, count and done on that edge. go=0 -> stay.
  - READ: R_en=1; temp <= R_Data at the edge; -> EVAL.
  - EVAL: temp <= MAX_DIGIT (unsigned) -> WRITE, else -> NEXT. No enables asserted.
  - WRITE: W_en=1; count <= count+1 at the edge; -> NEXT.
  - NEXT: i == DEPTH-1 -> DONE; else i <= i+1 -> READ.
  - DONE: done=1. go=0 -> IDLE (done stays 1); go=1 -> stay in DONE.
  - Unused encodings -> IDLE.
- Latency: 4 cycles per converted entry, 3 per skipped entry.
  - All 16 valid: busy high for 64 cycles; done rises on the edge after the final NEXT.
  - No valid entries: busy high for 48 cycles.
- count width ADDR_W+1 so the value DEPTH (16) is representable; it never wraps.
- i wraps are impossible: NEXT exits at DEPTH-1 before incrementing.
- Entries already in ASCII range (48..57) are > MAX_DIGIT, so they are skipped. A second scan of a converted table yields count=0 and no writes.
- go held high through a whole scan does not restart it. The block waits in DONE until go falls.
- go asserted while busy is ignored.
- Reset mid-scan: immediate return to IDLE with all outputs at reset values. Entries already written stay converted; no partial write occurs because W_en drops asynchronously.
- Register-file contents are never modified except in WRITE.

Optional Feature:
- Macro: DIGIT_ASCII_ERR_MARK_EN.
- Defined:
  - Adds output `err_count` (ADDR_W+1 bits, reset 0, cleared on start).
  - In EVAL, an entry that is > MAX_DIGIT and not in 48..57 goes to a MARK state: W_en=1, W_Data=63 ('?'), err_count+1, then NEXT. Takes 4 cycles.
  - Entries already ASCII digits are still skipped.
- Undefined: port and MARK state absent; invalid entries are skipped unchanged as described above.

Test Plan:
- Preload entry k = k mod 10, pulse go -> entries 0x30..0x39,0x30..0x35; count=16; done after 64 busy cycles; exactly 16 W_en pulses.
- Preload all 0x41 ('A') -> no W_en ever asserted; count=0; busy 48 cycles; contents unchanged.
- Mixed: entry3=7, entry9=0, entry15=9, others 200 -> entries 3/9/15 become 0x37/0x30/0x39; count=3; others stay 200.
  - With DIGIT_ASCII_ERR_MARK_EN, the others become 0x3F and err_count=13.
- Run the first scenario twice (go low between runs) -> second run count=0, no writes, done re-asserted; done=0 during the second busy window.
- Hold go=1 for 200 cycles -> exactly one scan; state stays DONE; go low -> IDLE with done=1.
- Assert Rst=0 at the 10th busy cycle of the first scenario -> busy/done/count/W_en go to 0 asynchronously; entries 0..1 converted, entry 2+ unchanged; next go performs a full scan with count=14.
